counterup16_ctrl: RTL and testbench

- 16-bit up counter with run control: start, synchronous clear, parallel load, compare-match, terminal-count and sticky overflow.
- Counts in the opposite direction to the existing 16-bit down counter and shares its clock/reset convention.
- Used as a timer/event counter benchmark block. It feeds downstream logic with a match pulse and status flags.

---
 rtl/counter_pkg.sv | 14 +
 rtl/upcnt_datapath.sv | 44 ++++
 rtl/counterup16_ctrl.sv | 109 ++++++++++
 tb/tb_counterup16_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and defaults for the up-counter block and its datapath.
package counter_pkg;

    // Control states: IDLE waits for start, RUN counts, HALT parks after an auto-stop match.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int          WIDTH_DEFAULT = 16;
    localparam logic [15:0] INIT_DEFAULT  = 16'h0000;

endpackage

// File: rtl/upcnt_datapath.sv
// Combinational next-value logic for the up counter: load mux, increment with
// carry-out, saturation hold, and the compare-match / terminal-count strobes.
module upcnt_datapath
    import counter_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             en_qual,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] next_count,
    output logic             match_next,
    output logic             tc_next
);

    logic [WIDTH:0] sum;
    logic           carry;

    assign sum   = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
    assign carry = sum[WIDTH];

    // Load beats increment; the increment's carry-out is the terminal-count source,
    // and a saturate-hold never counts as reaching the compare value.
    always_comb begin
        next_count = count;
        match_next = 1'b0;
        tc_next    = 1'b0;
        if (load) begin
            next_count = load_val;
        end else if (en_qual) begin
            tc_next = carry;
            if (carry && SATURATE) begin
                next_count = count;
            end else begin
                next_count = sum[WIDTH-1:0];
                match_next = (sum[WIDTH-1:0] == cmp_val);
            end
        end
    end

endmodule

// File: rtl/counterup16_ctrl.sv
// Up counter with run control: start/clear/load, compare match, terminal count
// and sticky overflow. Holds the control FSM and every register; the datapath
// sub-module only computes next values.
module counterup16_ctrl
    import counter_pkg::*;
#(
    parameter int             WIDTH     = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] INIT    = WIDTH'(INIT_DEFAULT),
    parameter bit             SATURATE  = 1'b0,
    parameter bit             AUTO_STOP = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             tc,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_next;
    logic             en_qual;
    logic [WIDTH-1:0] next_count;
    logic             match_next;
    logic             tc_next;
    logic             restart;

    assign en_qual = (state == RUN) && en;
    assign restart = (state == HALT) && start && !load;

    upcnt_datapath #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_datapath (
        .count      (count),
        .en_qual    (en_qual),
        .load       (load),
        .load_val   (load_val),
        .cmp_val    (cmp_val),
        .next_count (next_count),
        .match_next (match_next),
        .tc_next    (tc_next)
    );

    // State register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: clr always returns to IDLE; start is ignored while running.
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = RUN;
                RUN:     if (AUTO_STOP && match_next) state_next = HALT;
                HALT:    if (start) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Status outputs decoded straight from the state.
    always_comb begin
        busy = (state == RUN);
        done = (state == HALT);
    end

    // Counter and flag registers; match/tc are one-cycle strobes, ovf is sticky until clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= INIT;
            match <= 1'b0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= INIT;
            match <= 1'b0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            match <= match_next;
            tc    <= tc_next;
            if (tc_next) begin
                ovf <= 1'b1;
            end
            if (restart) begin
                count <= INIT;
            end else begin
                count <= next_count;
            end
        end
    end

endmodule

// File: tb/tb_counterup16_ctrl.sv
// Directed bench for counterup16_ctrl: three instances (default, auto-stop,
// saturating) share one stimulus stream; each step checks the relevant instance.
module tb_counterup16_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic        start;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] cmp_val;

    logic [15:0] cnt_a, cnt_b, cnt_c;
    logic        match_a, match_b, match_c;
    logic        tc_a, tc_b, tc_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    int vectors;
    int miscompares;

    counterup16_ctrl dut_a (
        .clk(clk), .reset(reset), .en(en), .start(start), .clr(clr), .load(load),
        .load_val(load_val), .cmp_val(cmp_val), .count(cnt_a), .match(match_a),
        .tc(tc_a), .ovf(ovf_a), .busy(busy_a), .done(done_a)
    );

    counterup16_ctrl #(.AUTO_STOP(1'b1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .start(start), .clr(clr), .load(load),
        .load_val(load_val), .cmp_val(cmp_val), .count(cnt_b), .match(match_b),
        .tc(tc_b), .ovf(ovf_b), .busy(busy_b), .done(done_b)
    );

    counterup16_ctrl #(.SATURATE(1'b1)) dut_c (
        .clk(clk), .reset(reset), .en(en), .start(start), .clr(clr), .load(load),
        .load_val(load_val), .cmp_val(cmp_val), .count(cnt_c), .match(match_c),
        .tc(tc_c), .ovf(ovf_c), .busy(busy_c), .done(done_c)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then land 1 ns after the next rising edge.
    task automatic applyStimulus(input logic s, input logic l, input logic e, input logic c,
                                 input logic [15:0] lv, input logic [15:0] cv);
        start    = s;
        load     = l;
        en       = e;
        clr      = c;
        load_val = lv;
        cmp_val  = cv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("[TB] %s miscompare", tag);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b0;
        en       = 1'b0;
        start    = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = 16'h0000;
        cmp_val  = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count", cnt_a, 16'h0000);
        checkOutput("rst_busy", {15'd0, busy_a}, 16'd0);
        checkOutput("rst_done", {15'd0, done_a}, 16'd0);
        checkOutput("rst_match", {15'd0, match_a}, 16'd0);
        checkOutput("rst_tc", {15'd0, tc_a}, 16'd0);
        checkOutput("rst_ovf", {15'd0, ovf_a}, 16'd0);
        #3 reset = 1'b1;

        // Plain counting with a match at 3
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003);
        checkOutput("start_busy", {15'd0, busy_a}, 16'd1);
        checkOutput("start_count", cnt_a, 16'h0000);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0003);
            checkOutput($sformatf("run_count%0d", i), cnt_a, 16'(i));
            checkOutput($sformatf("run_match%0d", i), {15'd0, match_a}, (i == 3) ? 16'd1 : 16'd0);
            checkOutput($sformatf("run_tc%0d", i), {15'd0, tc_a}, 16'd0);
        end
        checkOutput("run_done", {15'd0, done_a}, 16'd0);
        checkOutput("run_busy", {15'd0, busy_a}, 16'd1);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        checkOutput("clr_count", cnt_a, 16'h0000);
        checkOutput("clr_busy", {15'd0, busy_a}, 16'd0);

        // Auto-stop instance halts on match at 2, then restarts from INIT
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002);
        checkOutput("as_busy", {15'd0, busy_b}, 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002);
        checkOutput("as_count1", cnt_b, 16'h0001);
        checkOutput("as_match1", {15'd0, match_b}, 16'd0);
        checkOutput("as_done1", {15'd0, done_b}, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002);
        checkOutput("as_count2", cnt_b, 16'h0002);
        checkOutput("as_match2", {15'd0, match_b}, 16'd1);
        checkOutput("as_done2", {15'd0, done_b}, 16'd1);
        checkOutput("as_busy2", {15'd0, busy_b}, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002);
        checkOutput("as_hold_count", cnt_b, 16'h0002);
        checkOutput("as_hold_match", {15'd0, match_b}, 16'd0);
        checkOutput("as_hold_done", {15'd0, done_b}, 16'd1);
        checkOutput("as_tc", {15'd0, tc_b}, 16'd0);
        checkOutput("as_ovf", {15'd0, ovf_b}, 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002);
        checkOutput("as_restart_count", cnt_b, 16'h0000);
        checkOutput("as_restart_busy", {15'd0, busy_b}, 16'd1);
        checkOutput("as_restart_done", {15'd0, done_b}, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002);
        checkOutput("as_recount", cnt_b, 16'h0001);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);

        // Wrap (instance a) versus saturate (instance c) near all-ones
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFE, 16'hFFFF);
        checkOutput("wr_load_a", cnt_a, 16'hFFFE);
        checkOutput("wr_load_c", cnt_c, 16'hFFFE);
        checkOutput("wr_load_match", {15'd0, match_a}, 16'd0);
        checkOutput("wr_load_busy", {15'd0, busy_a}, 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF);
        checkOutput("wr_max_a", cnt_a, 16'hFFFF);
        checkOutput("wr_max_match_a", {15'd0, match_a}, 16'd1);
        checkOutput("wr_max_tc_a", {15'd0, tc_a}, 16'd0);
        checkOutput("wr_max_ovf_a", {15'd0, ovf_a}, 16'd0);
        checkOutput("sat_max_c", cnt_c, 16'hFFFF);
        checkOutput("sat_max_match_c", {15'd0, match_c}, 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF);
        checkOutput("wr_zero_a", cnt_a, 16'h0000);
        checkOutput("wr_zero_tc_a", {15'd0, tc_a}, 16'd1);
        checkOutput("wr_zero_ovf_a", {15'd0, ovf_a}, 16'd1);
        checkOutput("wr_zero_match_a", {15'd0, match_a}, 16'd0);
        checkOutput("sat_hold1_c", cnt_c, 16'hFFFF);
        checkOutput("sat_hold1_tc_c", {15'd0, tc_c}, 16'd1);
        checkOutput("sat_hold1_match_c", {15'd0, match_c}, 16'd0);
        checkOutput("sat_hold1_ovf_c", {15'd0, ovf_c}, 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF);
        checkOutput("wr_one_a", cnt_a, 16'h0001);
        checkOutput("wr_one_tc_a", {15'd0, tc_a}, 16'd0);
        checkOutput("wr_one_ovf_a", {15'd0, ovf_a}, 16'd1);
        checkOutput("sat_hold2_c", cnt_c, 16'hFFFF);
        checkOutput("sat_hold2_tc_c", {15'd0, tc_c}, 16'd1);
        checkOutput("sat_hold2_match_c", {15'd0, match_c}, 16'd0);
        checkOutput("sat_busy_c", {15'd0, busy_c}, 16'd1);
        checkOutput("sat_done_c", {15'd0, done_c}, 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF);
        checkOutput("start_in_run_a", cnt_a, 16'h0002);
        checkOutput("start_keeps_ovf_a", {15'd0, ovf_a}, 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF);
        checkOutput("en0_hold_a", cnt_a, 16'h0002);
        checkOutput("en0_tc_c", {15'd0, tc_c}, 16'd0);
        checkOutput("en0_hold_c", cnt_c, 16'hFFFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF);
        checkOutput("clr_ovf_a", {15'd0, ovf_a}, 16'd0);
        checkOutput("clr_ovf_c", {15'd0, ovf_c}, 16'd0);
        checkOutput("clr_count_a", cnt_a, 16'h0000);

        // Wrap to zero matches cmp_val 0, then clr beats load/start in RUN
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        checkOutput("wrap_match_zero", {15'd0, match_a}, 16'd1);
        checkOutput("wrap_tc", {15'd0, tc_a}, 16'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1235);
        checkOutput("ld_run_count", cnt_a, 16'h1234);
        checkOutput("ld_run_ovf", {15'd0, ovf_a}, 16'd1);
        checkOutput("ld_run_tc", {15'd0, tc_a}, 16'd0);
        checkOutput("ld_run_match", {15'd0, match_a}, 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, 16'h1235);
        checkOutput("clr_all_count", cnt_a, 16'h0000);
        checkOutput("clr_all_busy", {15'd0, busy_a}, 16'd0);
        checkOutput("clr_all_ovf", {15'd0, ovf_a}, 16'd0);
        checkOutput("clr_all_match", {15'd0, match_a}, 16'd0);
        checkOutput("clr_all_tc", {15'd0, tc_a}, 16'd0);

        // Asynchronous reset mid-cycle while running at 0x00A0
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h00A0, 16'h0000);
        checkOutput("pre_rst_count", cnt_a, 16'h00A0);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_rst_count", cnt_a, 16'h0000);
        checkOutput("async_rst_busy", {15'd0, busy_a}, 16'd0);
        #1 reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        checkOutput("post_rst_count", cnt_a, 16'h0000);
        checkOutput("post_rst_busy", {15'd0, busy_a}, 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0005);
        checkOutput("post_rst_start", {15'd0, busy_a}, 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0005);
        checkOutput("post_rst_count1", cnt_a, 16'h0001);
        checkOutput("cmp_old_match", {15'd0, match_a}, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002);
        checkOutput("cmp_new_count", cnt_a, 16'h0002);
        checkOutput("cmp_new_match", {15'd0, match_a}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
